agu_param: RTL and testbench
============================

AGU_PARAM -- requirements
Module: agu_param

Interface
REQ-001 Parameter BANKS, default 8, number of memory banks (power of two, 2..64).
REQ-002 Parameter AW, default 3, bank address width; SHALL equal log2(BANKS).
REQ-003 Parameter WR_LAT, default 4, read-to-write latency in advancing cycles, 1..16.
REQ-004 Port clk  input  1  clock; all state updates on posedge.
REQ-005 Port rst  input  1  reset; asynchronous, active-high.
REQ-006 Port start  input  1  begin one transform pass; sampled only in IDLE.
REQ-007 Port stall  input  1  freeze read and write sequencing for this cycle.
REQ-008 Port rd_valid  output  1  rd_addr holds a valid read vector this cycle.
REQ-009 Port rd_addr  output  BANKS*AW  per-bank read address; bank b in bits [b*AW +: AW].
REQ-010 Port rd_phase  output  1  0 = skew phase, 1 = row phase of current read vector.
REQ-011 Port wr_valid  output  1  wr_addr holds a valid write vector this cycle.
REQ-012 Port wr_addr  output  BANKS*AW  per-bank write address, same packing as rd_addr.
REQ-013 Port busy  output  1  high in RUN and DRAIN.
REQ-014 Port done  output  1  one-cycle pulse when the final write vector has been issued.

Function
REQ-015 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start=1; RUN->DRAIN after read vector 2*BANKS-1 issues; DRAIN->IDLE after final write vector issues.
REQ-016 Read counter c runs 0..2*BANKS-1, cleared on IDLE->RUN, increments once per RUN cycle with stall=0.
REQ-017 For c < BANKS (skew phase): bank b read address = (b - c) mod BANKS, rd_phase=0.
REQ-018 For c >= BANKS (row phase): every bank read address = c - BANKS, rd_phase=1.
REQ-019 Outputs registered: first rd_valid (c=0) SHALL appear in the cycle after start is sampled.
REQ-020 rd_valid=1 exactly in RUN cycles with stall=0; rd_addr holds last value otherwise.
REQ-021 Write channel: WR_LAT-deep valid/address shift register advanced only when stall=0; wr_addr/wr_valid equal the read vector issued WR_LAT advancing cycles earlier.
REQ-022 Exactly 2*BANKS read vectors and 2*BANKS write vectors per pass, in identical order.
REQ-023 stall=1: rd_valid=0, wr_valid=0, counter, FSM and pipeline frozen; done not asserted.
REQ-024 done pulses the cycle after the last wr_valid; busy falls in that same cycle.
REQ-025 start while busy=1 SHALL be ignored; start coincident with done SHALL be ignored (IDLE not yet entered).
REQ-026 Counter wrap: c SHALL NOT wrap; the row-phase address equals c - BANKS truncated to AW bits.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, c=0, pipeline valids=0, rd_valid=wr_valid=busy=done=0, rd_addr=wr_addr=0.
REQ-028 Reset mid-pass SHALL abort; no further valid or done until a new start after rst deasserts.

Configuration
REQ-029 Macro AGU_PARAM_BITREV_EN defined: extra input wr_bitrev (1 bit, sampled with start, held for the pass); when 1, each wr_addr lane is the AW-bit bit-reversal of the pipelined address.
REQ-030 Macro AGU_PARAM_BITREV_EN undefined: no wr_bitrev port; wr_addr is always the unmodified pipelined read address.

Verification (BANKS=8, AW=3, WR_LAT=4)
REQ-031 rst pulse mid-RUN at c=5 -> all outputs 0 same cycle; no done; restart gives c=0 vector 0,1,2,...,7.
REQ-032 start, no stall -> 16 rd_valid cycles; c=1 vector bank0..7 = 7,0,1,2,3,4,5,6; c=9 all lanes 1 with rd_phase=1.
REQ-033 start, no stall -> first wr_valid 4 cycles after first rd_valid, wr vectors equal rd vectors; done 1 cycle after 16th wr_valid; busy high exactly 21 cycles.
REQ-034 stall held 3 cycles at c=6 -> rd_valid/wr_valid low 3 cycles, sequence resumes at c=6 unchanged; done delayed by exactly 3 cycles.
REQ-035 start pulsed again at c=10 -> ignored; exactly 16 read and 16 write vectors, single done pulse.
REQ-036 AGU_PARAM_BITREV_EN defined, wr_bitrev=1 -> write vector for c=9 is all lanes 4 (bit-reverse of 001), c=1 lane0 = 7, lane1 = 0, lane2 = 4.

Source files
------------

// File: rtl/agu_param.sv
`default_nettype none
// ============================================================================
//  Module   : agu_param
//  Purpose  : Address generator for a BANKS-wide banked-memory transform pass.
//             One pass issues 2*BANKS read vectors. The first BANKS vectors
//             form the skew phase (bank b reads (b - c) mod BANKS). The last
//             BANKS vectors form the row phase (every bank reads c - BANKS).
//             The same vectors are replayed as write vectors WR_LAT
//             advancing cycles later. A stall freezes all sequencing.
//  Options  : AGU_PARAM_BITREV_EN adds input i_wr_bitrev. The input is
//             captured with start. When it is set, each write lane is
//             bit-reversed.
//  Revision : 1.0  initial release
// ============================================================================
module agu_param #(
  parameter int BANKS  = 8,
  parameter int AW     = 3,
  parameter int WR_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_stall,
`ifdef AGU_PARAM_BITREV_EN
  input  logic                i_wr_bitrev,
`endif
  output logic                o_rd_valid,
  output logic [BANKS*AW-1:0] o_rd_addr,
  output logic                o_rd_phase,
  output logic                o_wr_valid,
  output logic [BANKS*AW-1:0] o_wr_addr,
  output logic                o_busy,
  output logic                o_done
);

  localparam int          c_VW    = BANKS * AW;
  localparam logic [1:0]  c_IDLE  = 2'd0;
  localparam logic [1:0]  c_RUN   = 2'd1;
  localparam logic [1:0]  c_DRAIN = 2'd2;
  localparam logic [AW:0] c_LAST  = (AW + 1)'(2 * BANKS - 1);
  localparam logic [AW:0] c_ONE   = (AW + 1)'(1);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [AW:0]     r_cnt;
  logic [AW:0]     r_wcnt;
  logic            w_busy;
  logic            w_start_acc;
  logic            w_issue;
  logic            w_adv;
  logic            w_last_wr;
  logic            w_row;
  logic [c_VW-1:0] w_issue_addr;
  logic            r_rd_valid;
  logic            r_rd_phase;
  logic [c_VW-1:0] r_rd_addr;
  logic [WR_LAT-1:0] r_pipe_vld;
  logic [c_VW-1:0] r_pipe_addr [WR_LAT];
  logic            r_wr_valid;
  logic [c_VW-1:0] r_wr_addr;
  logic [c_VW-1:0] w_wr_addr_nxt;
  logic            r_done;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_start_acc) w_state_nxt = c_RUN;
      c_RUN:   if (w_issue && (r_cnt == c_LAST)) w_state_nxt = c_DRAIN;
      c_DRAIN: if (w_last_wr) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // FSM output/control decode. Start is ignored in the done cycle, so a
  // pulse that arrives with done never launches a new pass.
  // The final write has already left the block when it is seen here, so
  // the DRAIN exit does not wait for stall to drop.
  always_comb begin
    w_busy      = (r_state == c_RUN) || (r_state == c_DRAIN);
    w_start_acc = (r_state == c_IDLE) && i_start && !r_done;
    w_issue     = (r_state == c_RUN) && !i_stall;
    w_adv       = !i_stall;
    w_last_wr   = (r_state == c_DRAIN) && r_wr_valid && (r_wcnt == c_LAST);
  end

  // The counter MSB selects the phase. The low AW bits are either the skew
  // amount or the row index (c - BANKS truncated to AW bits).
  assign w_row = r_cnt[AW];

  generate
    for (genvar b = 0; b < BANKS; b++) begin : g_lane
      localparam logic [AW-1:0] c_LANE = AW'(b);
      assign w_issue_addr[b*AW +: AW] = w_row ? r_cnt[AW-1:0]
                                              : (c_LANE - r_cnt[AW-1:0]);
    end
  endgenerate

  // Read counter: cleared on pass launch, saturates at the last vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_start_acc) begin
      r_cnt <= '0;
    end else if (w_issue && (r_cnt != c_LAST)) begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

  // Registered read channel: the address and phase hold while no vector issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_phase <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      r_rd_valid <= w_issue;
      if (w_issue) begin
        r_rd_phase <= w_row;
        r_rd_addr  <= w_issue_addr;
      end
    end
  end

  // Write delay line: shifts only on advancing (non-stalled) cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < WR_LAT; i++) begin
        r_pipe_addr[i] <= '0;
      end
    end else if (w_adv) begin
      r_pipe_vld[0]  <= w_issue;
      r_pipe_addr[0] <= w_issue_addr;
      for (int i = 1; i < WR_LAT; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
    end
  end

`ifdef AGU_PARAM_BITREV_EN
  logic r_bitrev;

  function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = '0;
    for (int k = 0; k < AW; k++) begin
      r[k] = v[AW-1-k];
    end
    return r;
  endfunction

  // Bit-reverse mode is captured at launch and held for the whole pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitrev <= 1'b0;
    end else if (w_start_acc) begin
      r_bitrev <= i_wr_bitrev;
    end
  end

  generate
    for (genvar b = 0; b < BANKS; b++) begin : g_rev
      assign w_wr_addr_nxt[b*AW +: AW] =
        r_bitrev ? f_bitrev(r_pipe_addr[WR_LAT-1][b*AW +: AW])
                 : r_pipe_addr[WR_LAT-1][b*AW +: AW];
    end
  endgenerate
`else
  assign w_wr_addr_nxt = r_pipe_addr[WR_LAT-1];
`endif

  // Registered write channel. The delay line output is qualified by
  // the advance condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
    end else begin
      r_wr_valid <= w_adv && r_pipe_vld[WR_LAT-1];
      if (w_adv && r_pipe_vld[WR_LAT-1]) begin
        r_wr_addr <= w_wr_addr_nxt;
      end
    end
  end

  // Count emitted write vectors so the final one can be recognised
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if (w_start_acc) begin
      r_wcnt <= '0;
    end else if (r_wr_valid && (r_wcnt != c_LAST)) begin
      r_wcnt <= r_wcnt + c_ONE;
    end
  end

  // Done pulses in the cycle after the final write vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_wr;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_addr  = r_rd_addr;
  assign o_rd_phase = r_rd_phase;
  assign o_wr_valid = r_wr_valid;
  assign o_wr_addr  = r_wr_addr;
  assign o_busy     = w_busy;
  assign o_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_agu_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_agu_param
//  Purpose  : Self-checking bench for agu_param (BANKS=8, AW=3, WR_LAT=4).
//             A scoreboard queues the expected read and write vectors when a
//             pass is launched. Entries are popped as the DUT emits them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_agu_param;
  localparam int BANKS  = 8;
  localparam int AW     = 3;
  localparam int WR_LAT = 4;
  localparam int W      = BANKS * AW;
  localparam int NV     = 2 * BANKS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stall = 1'b0;
`ifdef AGU_PARAM_BITREV_EN
  logic         wr_bitrev = 1'b0;
`endif
  logic         rd_valid;
  logic [W-1:0] rd_addr;
  logic         rd_phase;
  logic         wr_valid;
  logic [W-1:0] wr_addr;
  logic         busy;
  logic         done;

  agu_param #(.BANKS(BANKS), .AW(AW), .WR_LAT(WR_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_stall    (stall),
`ifdef AGU_PARAM_BITREV_EN
    .i_wr_bitrev(wr_bitrev),
`endif
    .o_rd_valid (rd_valid),
    .o_rd_addr  (rd_addr),
    .o_rd_phase (rd_phase),
    .o_wr_valid (wr_valid),
    .o_wr_addr  (wr_addr),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [W:0]   rd_q [$];
  logic [W-1:0] wr_q [$];
  logic [W-1:0] rd_log [NV];
  logic [W-1:0] wr_log [NV];
  int           rd_cyc [NV];

  int p_nrd, p_nwr, p_rdfirst, p_wrfirst, p_wrlast, p_done, p_busy, p_ndone;

  function automatic logic [AW-1:0] model_lane(input int c, input int b);
    if (c < BANKS) return AW'((b - c + BANKS) % BANKS);
    else           return AW'(c - BANKS);
  endfunction

  function automatic logic [AW-1:0] model_rev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int k = 0; k < AW; k++) r[k] = v[AW-1-k];
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one pass from the current cycle (cycle 0). Scoreboard every emitted
  // vector and record the timing. stall_at/restart_at are read indices
  // (0 = unused). On the cycle before that vector would issue, the task
  // either stalls for stall_len cycles or pulses start.
  task automatic run_pass(input int stall_at, input int stall_len,
                          input int restart_at, input bit start_on_done,
                          input bit brev);
    int           stall_left;
    int           last_cyc;
    logic [W:0]   e_rd;
    logic [W-1:0] e_wr;
    rd_q.delete();
    wr_q.delete();
    for (int c = 0; c < NV; c++) begin
      for (int b = 0; b < BANKS; b++) begin
        e_rd[b*AW +: AW] = model_lane(c, b);
        e_wr[b*AW +: AW] = brev ? model_rev(model_lane(c, b)) : model_lane(c, b);
      end
      e_rd[W] = (c >= BANKS);
      rd_q.push_back(e_rd);
      wr_q.push_back(e_wr);
    end
    p_nrd = 0; p_nwr = 0; p_rdfirst = -1; p_wrfirst = -1; p_wrlast = -1;
    p_done = -1; p_busy = 0; p_ndone = 0;
    stall_left = 0;
    last_cyc = 200;
    start = 1'b1;
`ifdef AGU_PARAM_BITREV_EN
    wr_bitrev = brev;
`endif
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      tick();
      start = 1'b0;
      if (busy) p_busy++;
      if (rd_valid) begin
        n_vec++;
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_extra cyc=%0d got addr=%h, expected no vector", cyc, rd_addr);
        end else begin
          e_rd = rd_q.pop_front();
          if ({rd_phase, rd_addr} !== e_rd) begin
            n_err++;
            $display("FAIL rd_vec[%0d] got phase/addr=%h, expected %h", p_nrd, {rd_phase, rd_addr}, e_rd);
          end
          rd_log[p_nrd] = rd_addr;
          rd_cyc[p_nrd] = cyc;
          if (p_nrd == 0) p_rdfirst = cyc;
          if (p_nrd == stall_at - 1) stall_left = stall_len;
          if (p_nrd == restart_at - 1) start = 1'b1;
          p_nrd++;
        end
      end
      if (wr_valid) begin
        n_vec++;
        if (wr_q.size() == 0) begin
          n_err++;
          $display("FAIL wr_extra cyc=%0d got addr=%h, expected no vector", cyc, wr_addr);
        end else begin
          e_wr = wr_q.pop_front();
          if (wr_addr !== e_wr) begin
            n_err++;
            $display("FAIL wr_vec[%0d] got addr=%h, expected %h", p_nwr, wr_addr, e_wr);
          end
          wr_log[p_nwr] = wr_addr;
          if (p_nwr == 0) p_wrfirst = cyc;
          p_wrlast = cyc;
          p_nwr++;
        end
      end
      if (done) begin
        p_ndone++;
        n_vec++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL busy_at_done cyc=%0d got busy=%b, expected 0", cyc, busy);
        end
        if (p_done < 0) begin
          p_done = cyc;
          last_cyc = cyc + 6;
        end
        if (start_on_done) start = 1'b1;
      end
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else begin
        stall = 1'b0;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    n_vec++;
    if (p_done < 0) begin
      n_err++;
      $display("FAIL done_timeout got no done in 200 cycles, expected one");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick(); tick();
    n_vec++;
    if ({rd_valid, wr_valid, busy, done, rd_phase, rd_addr, wr_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got rdv=%b wrv=%b busy=%b done=%b rda=%h wra=%h, expected all 0",
               rd_valid, wr_valid, busy, done, rd_addr, wr_addr);
    end
    rst = 1'b0;
    tick(); tick();
    n_vec++;
    if ({rd_valid, wr_valid, busy, done} !== 4'b0) begin
      n_err++;
      $display("FAIL idle_after_reset got rdv=%b wrv=%b busy=%b done=%b, expected 0",
               rd_valid, wr_valid, busy, done);
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] exp_c1;
    logic [W-1:0] exp_c9;
    exp_c1 = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    exp_c9 = {8{3'd1}};
    run_pass(0, 0, 0, 1'b0, 1'b0);
    n_vec++;
    if (p_nrd !== 16 || p_nwr !== 16) begin
      n_err++;
      $display("FAIL basic_counts got rd=%0d wr=%0d, expected 16/16", p_nrd, p_nwr);
    end
    n_vec++;
    if (p_rdfirst !== 2) begin
      n_err++;
      $display("FAIL basic_rd_first got cyc %0d, expected 2", p_rdfirst);
    end
    n_vec++;
    if (p_wrfirst - p_rdfirst !== WR_LAT) begin
      n_err++;
      $display("FAIL basic_wr_lat got %0d, expected %0d", p_wrfirst - p_rdfirst, WR_LAT);
    end
    n_vec++;
    if (p_done !== p_wrlast + 1 || p_done !== 22) begin
      n_err++;
      $display("FAIL basic_done_cyc got %0d (last wr %0d), expected 22", p_done, p_wrlast);
    end
    n_vec++;
    if (p_busy !== 21) begin
      n_err++;
      $display("FAIL basic_busy_len got %0d, expected 21", p_busy);
    end
    n_vec++;
    if (rd_log[1] !== exp_c1) begin
      n_err++;
      $display("FAIL basic_rd_c1 got %h, expected %h", rd_log[1], exp_c1);
    end
    n_vec++;
    if (rd_log[9] !== exp_c9) begin
      n_err++;
      $display("FAIL basic_rd_c9 got %h, expected %h", rd_log[9], exp_c9);
    end
    n_vec++;
    if (p_ndone !== 1) begin
      n_err++;
      $display("FAIL basic_done_count got %0d, expected 1", p_ndone);
    end
  endtask

  task automatic test_stall;
    run_pass(6, 3, 0, 1'b0, 1'b0);
    n_vec++;
    if (p_nrd !== 16 || p_nwr !== 16) begin
      n_err++;
      $display("FAIL stall_counts got rd=%0d wr=%0d, expected 16/16", p_nrd, p_nwr);
    end
    n_vec++;
    if (rd_cyc[6] - rd_cyc[5] !== 4) begin
      n_err++;
      $display("FAIL stall_gap got %0d, expected 4", rd_cyc[6] - rd_cyc[5]);
    end
    n_vec++;
    if (p_done !== 25) begin
      n_err++;
      $display("FAIL stall_done_cyc got %0d, expected 25", p_done);
    end
    n_vec++;
    if (p_busy !== 24) begin
      n_err++;
      $display("FAIL stall_busy_len got %0d, expected 24", p_busy);
    end
  endtask

  task automatic test_start_ignored;
    run_pass(0, 0, 10, 1'b1, 1'b0);
    n_vec++;
    if (p_nrd !== 16 || p_nwr !== 16 || p_ndone !== 1) begin
      n_err++;
      $display("FAIL restart_counts got rd=%0d wr=%0d done=%0d, expected 16/16/1",
               p_nrd, p_nwr, p_ndone);
    end
    n_vec++;
    if (p_done !== 22 || p_busy !== 21) begin
      n_err++;
      $display("FAIL restart_timing got done=%0d busy=%0d, expected 22/21", p_done, p_busy);
    end
  endtask

  task automatic test_reset_midpass;
    int           seen;
    bit           got;
    bit           quiet;
    logic [W-1:0] exp_c0;
    exp_c0 = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    seen = 0;
    got = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      start = 1'b0;
      if (rd_valid) begin
        if (seen == 5) got = 1'b1;
        else seen++;
      end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL midpass_reach got %0d vectors, expected to reach c=5", seen);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({rd_valid, wr_valid, busy, done, rd_addr, wr_addr} !== '0) begin
      n_err++;
      $display("FAIL midpass_rst got rdv=%b wrv=%b busy=%b done=%b rda=%h wra=%h, expected all 0",
               rd_valid, wr_valid, busy, done, rd_addr, wr_addr);
    end
    #2;
    rst = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (rd_valid || wr_valid || done || busy) quiet = 1'b0;
    end
    n_vec++;
    if (!quiet) begin
      n_err++;
      $display("FAIL midpass_quiet got activity after abort, expected none");
    end
    run_pass(0, 0, 0, 1'b0, 1'b0);
    n_vec++;
    if (rd_log[0] !== exp_c0 || p_ndone !== 1) begin
      n_err++;
      $display("FAIL midpass_restart got c0=%h done=%0d, expected %h/1", rd_log[0], p_ndone, exp_c0);
    end
  endtask

`ifdef AGU_PARAM_BITREV_EN
  task automatic test_bitrev;
    run_pass(0, 0, 0, 1'b0, 1'b1);
    n_vec++;
    if (wr_log[9] !== {8{3'd4}}) begin
      n_err++;
      $display("FAIL bitrev_c9 got %h, expected %h", wr_log[9], {8{3'd4}});
    end
    n_vec++;
    if (wr_log[1][8:0] !== {3'd4, 3'd0, 3'd7}) begin
      n_err++;
      $display("FAIL bitrev_c1 got lanes2..0=%h, expected %h", wr_log[1][8:0], {3'd4, 3'd0, 3'd7});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    tick(); tick();
    test_stall();
    tick(); tick();
    test_start_ignored();
    tick(); tick();
    test_reset_midpass();
`ifdef AGU_PARAM_BITREV_EN
    tick(); tick();
    test_bitrev();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
